// File: rtl/cmd_stream_sched_pkg.sv
// Shared constants and state encoding for the UART/keyboard command stream scheduler.
// The escape-lock helper is used only when CMD_ESC_LOCK_EN is defined.
package vgaminikbd_pkg;

   localparam logic SRC_UART = 1'b0;
   localparam logic SRC_KBD  = 1'b1;

   localparam logic [7:0] ESC          = 8'h1B;
   localparam logic [7:0] CSI_BRACKET  = 8'h5B;
   localparam logic [7:0] ESC_FINAL_LO = 8'h40;
   localparam logic [7:0] ESC_FINAL_HI = 8'h7E;

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } sched_state_e;

   // A '[' straight after ESC opens a CSI sequence rather than ending it.
   function automatic logic is_esc_final(input logic [7:0] b, input logic after_esc);
      return (b >= ESC_FINAL_LO) && (b <= ESC_FINAL_HI) && !(after_esc && (b == CSI_BRACKET));
   endfunction

endpackage

// File: rtl/cmd_stream_sched_fifo.sv
// Small synchronous byte FIFO; a push into a full FIFO is accepted only when a pop
// happens in the same cycle, otherwise the caller sees the drop via full.
module byte_fifo
   import vgaminikbd_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic [7:0] din,
   input  logic       pop,
   output logic [7:0] dout,
   output logic       empty,
   output logic       full
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem_q[rd_q];

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din;
   end

endmodule

// File: rtl/cmd_stream_sched.sv
// Buffers the UART RX and keyboard byte streams and merges them round-robin onto one
// valid/ready output. Define CMD_ESC_LOCK_EN to keep escape sequences contiguous.
module cmd_stream_sched
   import vgaminikbd_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int LOCK_TIMEOUT = 1023
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] d0,
   input  logic       d0v,
   input  logic [7:0] d1,
   input  logic       d1v,
   output logic [7:0] od,
   output logic       odv,
   input  logic       ordy,
   output logic       grant,
   output logic       ovf0,
   output logic       ovf1,
   input  logic       clr_err
);

   // Handshake: a byte transfers on every cycle where odv and ordy are both high;
   // od/grant never change while odv is high and ordy is low.
   sched_state_e state_q, state_d;
   logic [7:0]   od_q, od_d, dout0, dout1, sel_byte;
   logic         odv_q, odv_d, grant_q, grant_d, ovf0_q, ovf0_d, ovf1_q, ovf1_d;
   logic         empty0, empty1, full0, full1, pop0, pop1;
   logic         elig0, elig1, sel, take, load;

   byte_fifo #(.DEPTH(DEPTH)) u_fifo0 (
      .clk(clk), .reset(reset), .push(d0v), .din(d0), .pop(pop0),
      .dout(dout0), .empty(empty0), .full(full0)
   );

   byte_fifo #(.DEPTH(DEPTH)) u_fifo1 (
      .clk(clk), .reset(reset), .push(d1v), .din(d1), .pop(pop1),
      .dout(dout1), .empty(empty1), .full(full1)
   );

   assign sel      = (elig0 && elig1) ? !grant_q : elig1;
   assign take     = (state_q == IDLE) || ordy;
   assign load     = take && (elig0 || elig1);
   assign pop0     = load && (sel == SRC_UART);
   assign pop1     = load && (sel == SRC_KBD);
   assign sel_byte = sel ? dout1 : dout0;

`ifdef CMD_ESC_LOCK_EN
   localparam int TW = $clog2(LOCK_TIMEOUT + 1);

   logic          lock_q, lock_d, lock_src_q, lock_src_d, after_esc_q, after_esc_d;
   logic          src_pop, src_empty;
   logic [TW-1:0] tmo_q, tmo_d;

   assign elig0     = !empty0 && !(lock_q && (lock_src_q != SRC_UART));
   assign elig1     = !empty1 && !(lock_q && (lock_src_q != SRC_KBD));
   assign src_pop   = (lock_src_q == SRC_KBD) ? pop1 : pop0;
   assign src_empty = (lock_src_q == SRC_KBD) ? empty1 : empty0;

   always_comb begin
      lock_d      = lock_q;
      lock_src_d  = lock_src_q;
      after_esc_d = after_esc_q;
      tmo_d       = tmo_q;
      if (!lock_q) begin
         tmo_d = '0;
         if (load && (sel_byte == ESC)) begin
            lock_d      = 1'b1;
            lock_src_d  = sel;
            after_esc_d = 1'b1;
         end
      end else if (src_pop) begin
         tmo_d       = '0;
         after_esc_d = (sel_byte == ESC);
         if (is_esc_final(sel_byte, after_esc_q)) lock_d = 1'b0;
      end else if (!src_empty) begin
         tmo_d = '0;
      end else if (tmo_q == TW'(LOCK_TIMEOUT - 1)) begin
         // Locked source stayed silent too long: give the other source its turn back.
         lock_d = 1'b0;
         tmo_d  = '0;
      end else begin
         tmo_d = tmo_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lock_q      <= 1'b0;
         lock_src_q  <= SRC_UART;
         after_esc_q <= 1'b0;
         tmo_q       <= '0;
      end else begin
         lock_q      <= lock_d;
         lock_src_q  <= lock_src_d;
         after_esc_q <= after_esc_d;
         tmo_q       <= tmo_d;
      end
   end
`else
   logic unused_lock_cfg;

   assign elig0           = !empty0;
   assign elig1           = !empty1;
   assign unused_lock_cfg = (LOCK_TIMEOUT > 0);
`endif

   always_comb begin
      state_d = state_q;
      od_d    = od_q;
      odv_d   = odv_q;
      grant_d = grant_q;
      case (state_q)
         IDLE: begin
            if (load) begin
               od_d    = sel_byte;
               grant_d = sel;
               odv_d   = 1'b1;
               state_d = PRESENT;
            end
         end
         PRESENT: begin
            if (load) begin
               od_d    = sel_byte;
               grant_d = sel;
            end else if (ordy) begin
               odv_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A drop outranks a simultaneous clear so no overflow event is ever lost.
   assign ovf0_d = (d0v && full0 && !pop0) || (ovf0_q && !clr_err);
   assign ovf1_d = (d1v && full1 && !pop1) || (ovf1_q && !clr_err);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         od_q    <= 8'h00;
         odv_q   <= 1'b0;
         grant_q <= SRC_KBD;
         ovf0_q  <= 1'b0;
         ovf1_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         od_q    <= od_d;
         odv_q   <= odv_d;
         grant_q <= grant_d;
         ovf0_q  <= ovf0_d;
         ovf1_q  <= ovf1_d;
      end
   end

   assign od    = od_q;
   assign odv   = odv_q;
   assign grant = grant_q;
   assign ovf0  = ovf0_q;
   assign ovf1  = ovf1_q;

endmodule

// File: tb/tb_cmd_stream_sched.sv
// Self-checking bench for cmd_stream_sched; escape-lock scenarios run when
// CMD_ESC_LOCK_EN is defined.
module tb_cmd_stream_sched;

   localparam int DEPTH        = 4;
   localparam int LOCK_TIMEOUT = 64;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] d0 = 8'h00, d1 = 8'h00;
   logic       d0v = 1'b0, d1v = 1'b0, ordy = 1'b0, clr_err = 1'b0;
   logic [7:0] od;
   logic       odv, grant, ovf0, ovf1;

   int total = 0;
   int bad = 0;

   // Entries are {grant, byte}.
   logic [8:0] exp_q[$];
   logic [8:0] obs_q[$];

   cmd_stream_sched #(.DEPTH(DEPTH), .LOCK_TIMEOUT(LOCK_TIMEOUT)) dut (
      .clk(clk), .reset(reset), .d0(d0), .d0v(d0v), .d1(d1), .d1v(d1v),
      .od(od), .odv(odv), .ordy(ordy), .grant(grant), .ovf0(ovf0), .ovf1(ovf1),
      .clr_err(clr_err)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!reset && odv && ordy) obs_q.push_back({grant, od});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; d0v = 1'b0; d1v = 1'b0; ordy = 1'b0; clr_err = 1'b0;
      tick();
      reset = 1'b0;
      obs_q.delete();
      exp_q.delete();
   endtask

   // ---------------- scoreboard drain ----------------
   task automatic drain(input string name, input int budget);
      int n;
      int t;
      logic [8:0] e, o;
      n = exp_q.size();
      t = 0;
      while (obs_q.size() < n && t < budget) begin
         tick();
         t++;
      end
      repeat (4) tick();
      total++;
      if (obs_q.size() != n) begin
         bad++;
         $display("FAIL %s_count got=%0d want=%0d", name, obs_q.size(), n);
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL %s_data got grant=%0b od=%02h want grant=%0b od=%02h",
                     name, o[8], o[7:0], e[8], e[7:0]);
         end
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      @(negedge clk);
      total++; if (od !== 8'h00)  begin bad++; $display("FAIL rst_od got=%02h want=00", od); end
      total++; if (odv !== 1'b0)  begin bad++; $display("FAIL rst_odv got=%0b want=0", odv); end
      total++; if (grant !== 1'b1) begin bad++; $display("FAIL rst_grant got=%0b want=1", grant); end
      total++; if (ovf0 !== 1'b0) begin bad++; $display("FAIL rst_ovf0 got=%0b want=0", ovf0); end
      total++; if (ovf1 !== 1'b0) begin bad++; $display("FAIL rst_ovf1 got=%0b want=0", ovf1); end
   endtask

   task automatic test_single();
      do_reset();
      ordy = 1'b1;
      d0 = 8'h41; d0v = 1'b1; exp_q.push_back({1'b0, 8'h41});
      tick();
      d0v = 1'b0;
      @(negedge clk);
      total++; if (odv !== 1'b0) begin bad++; $display("FAIL single_n1_odv got=%0b want=0", odv); end
      tick();
      @(negedge clk);
      total++; if (odv !== 1'b1) begin bad++; $display("FAIL single_n2_odv got=%0b want=1", odv); end
      total++; if (od !== 8'h41) begin bad++; $display("FAIL single_n2_od got=%02h want=41", od); end
      total++; if (grant !== 1'b0) begin bad++; $display("FAIL single_n2_grant got=%0b want=0", grant); end
      tick();
      @(negedge clk);
      total++; if (odv !== 1'b0) begin bad++; $display("FAIL single_n3_odv got=%0b want=0", odv); end
      drain("single", 20);
   endtask

   task automatic test_simultaneous();
      do_reset();
      ordy = 1'b1;
      d0 = 8'h31; d0v = 1'b1; d1 = 8'h61; d1v = 1'b1;
      exp_q.push_back({1'b0, 8'h31});
      exp_q.push_back({1'b1, 8'h61});
      tick();
      d0v = 1'b0; d1v = 1'b0;
      tick();
      @(negedge clk);
      total++; if ({odv, grant, od} !== {2'b10, 8'h31}) begin
         bad++; $display("FAIL simul_first got odv=%0b grant=%0b od=%02h want 1/0/31", odv, grant, od);
      end
      tick();
      @(negedge clk);
      total++; if ({odv, grant, od} !== {2'b11, 8'h61}) begin
         bad++; $display("FAIL simul_second got odv=%0b grant=%0b od=%02h want 1/1/61", odv, grant, od);
      end
      drain("simul", 20);
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int i = 0; i < 6; i++) begin
         d1 = 8'h10 + 8'(i); d1v = 1'b1;
         if (i < 5) exp_q.push_back({1'b1, 8'h10 + 8'(i)});
         tick();
      end
      d1v = 1'b0;
      @(negedge clk);
      total++; if ({odv, grant, od} !== {2'b11, 8'h10}) begin
         bad++; $display("FAIL bp_present got odv=%0b grant=%0b od=%02h want 1/1/10", odv, grant, od);
      end
      total++; if (ovf1 !== 1'b1) begin bad++; $display("FAIL bp_ovf1_set got=%0b want=1", ovf1); end
      total++; if (ovf0 !== 1'b0) begin bad++; $display("FAIL bp_ovf0_clean got=%0b want=0", ovf0); end
      repeat (3) tick();
      @(negedge clk);
      total++; if (od !== 8'h10) begin bad++; $display("FAIL bp_hold got=%02h want=10", od); end
      ordy = 1'b1;
      drain("bp", 30);
      total++; if (ovf1 !== 1'b1) begin bad++; $display("FAIL bp_ovf1_sticky got=%0b want=1", ovf1); end
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      @(negedge clk);
      total++; if (ovf1 !== 1'b0) begin bad++; $display("FAIL bp_ovf1_clear got=%0b want=0", ovf1); end
   endtask

   task automatic test_ovf_clear_race();
      do_reset();
      for (int i = 0; i < 6; i++) begin
         d0 = 8'h50 + 8'(i); d0v = 1'b1;
         if (i < 5) exp_q.push_back({1'b0, 8'h50 + 8'(i)});
         tick();
      end
      d0 = 8'h56; clr_err = 1'b1;
      tick();
      d0v = 1'b0; clr_err = 1'b0;
      @(negedge clk);
      total++; if (ovf0 !== 1'b1) begin bad++; $display("FAIL race_drop_wins got=%0b want=1", ovf0); end
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      @(negedge clk);
      total++; if (ovf0 !== 1'b0) begin bad++; $display("FAIL race_clear got=%0b want=0", ovf0); end
      ordy = 1'b1;
      drain("race", 30);
   endtask

   task automatic test_fairness();
      logic [8:0] o;
      logic       prev;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         d0 = 8'hA0 + 8'(i); d0v = 1'b1;
         d1 = 8'hB0 + 8'(i); d1v = (i < 4);
         tick();
      end
      d0v = 1'b0; d1v = 1'b0;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back({1'b0, 8'hA0 + 8'(i)});
         exp_q.push_back({1'b1, 8'hB0 + 8'(i)});
      end
      exp_q.push_back({1'b0, 8'hA4});
      ordy = 1'b1;
      repeat (14) tick();
      prev = 1'b1;
      for (int i = 0; i < obs_q.size(); i++) begin
         o = obs_q[i];
         total++;
         if (o[8] === prev) begin
            bad++; $display("FAIL fair_alternate idx=%0d got grant=%0b want=%0b", i, o[8], !prev);
         end
         prev = o[8];
      end
      total++; if ({ovf0, ovf1} !== 2'b00) begin
         bad++; $display("FAIL fair_no_ovf got=%0b%0b want=00", ovf0, ovf1);
      end
      drain("fair", 10);
   endtask

   task automatic test_reset_midstream();
      do_reset();
      for (int i = 0; i < 6; i++) begin
         d0 = 8'hC0 + 8'(i); d0v = 1'b1;
         d1 = 8'hD0 + 8'(i); d1v = (i < 3);
         tick();
      end
      d0v = 1'b0; d1v = 1'b0;
      @(negedge clk);
      total++; if ({odv, ovf0} !== 2'b11) begin
         bad++; $display("FAIL mid_pre got odv=%0b ovf0=%0b want 1/1", odv, ovf0);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      total++; if ({odv, od} !== {1'b0, 8'h00}) begin
         bad++; $display("FAIL mid_post got odv=%0b od=%02h want 0/00", odv, od);
      end
      total++; if ({ovf0, ovf1} !== 2'b00) begin
         bad++; $display("FAIL mid_ovf got=%0b%0b want=00", ovf0, ovf1);
      end
      obs_q.delete();
      ordy = 1'b1;
      repeat (8) tick();
      d1 = 8'h77; d1v = 1'b1; exp_q.push_back({1'b1, 8'h77});
      tick();
      d1v = 1'b0;
      drain("mid", 20);
   endtask

`ifdef CMD_ESC_LOCK_EN
   task automatic test_esc_lock();
      logic [7:0] seq [4];
      do_reset();
      seq[0] = 8'h1B; seq[1] = 8'h5B; seq[2] = 8'h32; seq[3] = 8'h4A;
      ordy = 1'b1;
      d1 = 8'h61; d1v = 1'b1;
      for (int i = 0; i < 4; i++) begin
         d0 = seq[i]; d0v = 1'b1;
         exp_q.push_back({1'b0, seq[i]});
         tick();
         d1v = 1'b0;
      end
      d0v = 1'b0;
      exp_q.push_back({1'b1, 8'h61});
      drain("esc", 40);
   endtask

   task automatic test_esc_timeout();
      int t;
      do_reset();
      ordy = 1'b1;
      d0 = 8'h1B; d0v = 1'b1; d1 = 8'h61; d1v = 1'b1;
      tick();
      d1v = 1'b0; d0 = 8'h5B;
      tick();
      d0v = 1'b0;
      exp_q.push_back({1'b0, 8'h1B});
      exp_q.push_back({1'b0, 8'h5B});
      exp_q.push_back({1'b1, 8'h61});
      t = 0;
      while (obs_q.size() < 3 && t < LOCK_TIMEOUT + 50) begin
         tick();
         t++;
      end
      total++; if (t < LOCK_TIMEOUT || t > LOCK_TIMEOUT + 6) begin
         bad++; $display("FAIL esc_timeout_delay got=%0d want=%0d..%0d", t, LOCK_TIMEOUT, LOCK_TIMEOUT + 6);
      end
      drain("esc_tmo", 10);
   endtask
`endif

   // ---------------- sequence / report ----------------
   initial begin
      test_reset();
      test_single();
      test_simultaneous();
      test_backpressure();
      test_ovf_clear_race();
      test_fairness();
      test_reset_midstream();
`ifdef CMD_ESC_LOCK_EN
      test_esc_lock();
      test_esc_timeout();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cmd_stream_sched.md
Name: cmd_stream_sched

Overview:
- Schedules the two byte streams feeding the VGA command input: UART RX (CPU text/commands) and the PS/2 keyboard ASCII stream.
- Buffers each source in its own small FIFO, then merges them fairly (round-robin) onto one valid/ready byte output for the vga block.
- Reports per-source overflow and replaces the unbuffered 2-input data mux between the uart/kbd blocks and vga.

Parameters:
- DEPTH, 4: entries per source FIFO; power of 2, at least 2.
- LOCK_TIMEOUT, 1023: idle cycles after which an escape-sequence lock is abandoned (used only with the optional feature).

Ports:
- clk  in  1  system clock (24 MHz pixel clock domain)
- reset  in  1  reset; one clock; reset is synchronous and active-high
- d0  in  8  UART RX byte
- d0v  in  1  single-cycle strobe: d0 valid
- d1  in  8  keyboard ASCII byte
- d1v  in  1  single-cycle strobe: d1 valid
- od  out  8  scheduled byte to vga
- odv  out  1  od valid
- ordy  in  1  sink ready; tied high at top level until vga gains backpressure
- grant  out  1  source of the byte currently or last presented (0 = UART, 1 = keyboard)
- ovf0  out  1  sticky: d0 byte dropped
- ovf1  out  1  sticky: d1 byte dropped
- clr_err  in  1  synchronous clear of ovf0/ovf1

Behaviour:
- Reset values: od=0, odv=0, grant=1 (so d0 wins the first tie), ovf0=ovf1=0. Both FIFOs are emptied.
- Reset asserted mid-operation discards all buffered bytes and any presented byte. No partial handshake survives reset.
- FIFO push on dNv:
  - Not full: accepted.
  - Full and popped in the same cycle: accepted, count unchanged.
  - Full and not popped: byte dropped and ovfN set.
- ovfN stays set until clr_err. If clr_err and a new drop occur in the same cycle, the drop wins (flag stays 1).
- Output is a valid/ready register. od and grant are held stable while odv=1 and ordy=0.
- States:
  - IDLE: odv=0. If any FIFO is non-empty, select a source, load od from its head, pop it, set grant, then go to PRESENT.
  - PRESENT: odv=1. On odv&&ordy: if any FIFO is non-empty, reload od in the same cycle (odv stays 1, one byte/cycle throughput). Otherwise clear odv and go to IDLE.
- Selection rule:
  - Only one source non-empty: pick it.
  - Both non-empty: pick !grant (alternate).
- Latency: a byte strobed into an empty scheduler in cycle N has odv=1 with that byte on od in cycle N+2.
- Ordering: bytes from one source leave in arrival order. No byte is duplicated.

Optional Feature:
- Macro: CMD_ESC_LOCK_EN.
- With the macro:
  - A byte 0x1B popped from source s locks grant to s. The other source is not served; it keeps buffering and may overflow.
  - The lock releases after the sequence final byte. The final byte is the first popped byte in 0x40..0x7E that is not the '[' (0x5B) immediately following 0x1B.
  - The lock also releases when source s's FIFO stays empty for LOCK_TIMEOUT consecutive cycles. The timeout counter resets on every pop from s.
  - Round-robin resumes after release, with grant=s.
- Without the macro: pure round-robin; no lock logic or counter is synthesized.

Decomposition:
- Package vgaminikbd_pkg holds:
  - SRC_UART=1'b0 and SRC_KBD=1'b1
  - ESC=8'h1B, CSI_BRACKET=8'h5B
  - ESC_FINAL_LO=8'h40, ESC_FINAL_HI=8'h7E
  - FSM state encoding IDLE/PRESENT
- Sub-module byte_fifo (parameter DEPTH; ports push/din/pop/dout/empty/full), instanced twice.

Test Plan:
- Single byte: d0=0x41 strobed in cycle 10, ordy=1 -> od=0x41, odv=1, grant=0 in cycle 12; odv=0 in cycle 13.
- Simultaneous strobes d0=0x31 and d1=0x61 in the same cycle, ordy=1 -> od sequence 0x31 then 0x61 on consecutive cycles; grant 0 then 1.
- Backpressure: ordy=0, push d1 = 0x10..0x14 (5 bytes, DEPTH=4). Expected:
  - od=0x10 held.
  - After the FIFO fills with 0x11..0x14, a sixth byte 0x15 is dropped and ovf1=1.
  - Releasing ordy drains 0x11..0x14 in order.
  - A clr_err pulse then clears ovf1.
- Fairness: both sources continuously non-empty (d0=0xA0.., d1=0xB0..) -> grant alternates every handshake; no source gets two consecutive grants.
- Reset mid-stream: reset pulsed while odv=1 and both FIFOs hold bytes -> next cycle odv=0, od=0, ovf=0. No pre-reset byte ever appears afterwards.
- With CMD_ESC_LOCK_EN:
  - d0 sends 1B 5B 32 4A while d1 streams 0x61. Expected od: 1B 5B 32 4A contiguous, then 0x61.
  - Repeat with d0 stopping after 1B 5B -> lock releases LOCK_TIMEOUT cycles later and 0x61 follows.
